dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter sharing the single-ported data memory between the SCPU load/store port (master 0) and a secondary bus master (master 1: DMA or debug loader). Arbitrates one access per cycle, steers address/write data/strobes to the memory, and routes the one-cycle-latency read data back to the master that issued the read. Sits between the CPU data port and `my_data_memory` in the SoC top, with the instruction path untouched.

## Interface
- `ARB_MODE`, 0: 0 = fixed priority to master 0 with starvation guard; 1 = round-robin.
- `MAX_WAIT`, 8: cycles master 1 may wait under `ARB_MODE`=0 before it is forced to win; 0 disables the guard.
- `AW`, 32: address width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `m0_req`, `m1_req`  in  1  access request, held until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  AW  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte write enables.
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered).
- `m0_rdata`, `m1_rdata`  out  32  read data; equals `mem_rdata` when the matching rvalid is set, else 0.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  AW  address to memory.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  byte strobes; 0 on reads.
- `mem_rdata`  in  32  synchronous read data, valid the cycle after a read is issued.

## Operation
- Each cycle, at most one master is granted; the grant is decided combinationally from the current reqs and the registered state (`last_gnt`, `wait_cnt`).
- Exactly one `mX_gnt` is high while `mem_en` is high; the memory bus carries the granted master's signals. With no grant, `mem_en`=0 and `mem_we`=0, `mem_wstrb`=0, `mem_addr`/`mem_wdata`=0.
- `ARB_MODE`=0: master 0 wins any conflict unless `MAX_WAIT`≠0 and `wait_cnt`==`MAX_WAIT`, in which case master 1 wins.
- `wait_cnt` increments each cycle `m1_req` is high without `m1_gnt`, saturates at `MAX_WAIT`, and clears on `m1_gnt` or when `m1_req` is low.
- `ARB_MODE`=1: on a conflict, the master other than `last_gnt` wins. `last_gnt` updates on every grant.
- Single requester: that requester is granted immediately in both modes.
- Writes complete in the grant cycle; no response.
- Reads: the registered `rd_owner` (none/0/1) is set on a read grant. The next cycle raises that master's rvalid with `mem_rdata`.
- Back-to-back accesses are allowed; a new grant may coincide with the rvalid of the previous read.
- A master dropping req before grant is legal and issues nothing.

## Timing
- Reset (rst=0, asynchronous):
  - `rd_owner`=none, so both rvalids are 0.
  - `last_gnt`=1, so master 0 wins the first round-robin conflict.
  - `wait_cnt`=0.
  - Both gnts and `mem_en` are forced to 0 while rst=0.
- Grant latency: 0 cycles with no contention. Read data latency: 1 cycle after gnt.
- Throughput: 1 access/cycle sustained.
- Reset mid-read: the pending rvalid is dropped and never delivered after reset release.
- Worst-case master 1 wait under mode 0 is `MAX_WAIT`+1 cycles; master 0 then loses exactly one cycle.
- Simultaneous read grant and pending rvalid for the other master: both proceed in that cycle, with no data mixing.

## Test plan
- Reset: hold rst=0 with both reqs high -> both gnts=0, `mem_en`=0, both rvalids=0; release -> master 0 granted the first cycle (both modes).
- Single read: m1 reads 0x0000_0010 with memory preloaded 0xDEADBEEF -> `m1_gnt` the same cycle, `m1_rvalid`=1 and `m1_rdata`=0xDEADBEEF the next cycle, `m0_rvalid`=0.
- Mode 0 starvation, `MAX_WAIT`=8: both req continuously -> m0 granted 8 cycles, m1 granted on the 9th, pattern repeats every 9 cycles.
- Mode 1: both req continuously with alternating reads -> grants alternate m0, m1, m0…; each rvalid lands on the correct master one cycle after its gnt.
- Back-to-back: m0 writes 0x1234_5678 to 0x20 with wstrb=0xF, then m1 reads 0x20 the next cycle -> `m1_rdata`=0x1234_5678.
- Reset mid-read: assert rst=0 in the cycle after an m0 read gnt -> `m0_rvalid` stays 0 throughout and after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data memory arbiter with read-data return routing
//
// Shares one single-ported, one-cycle-latency data memory between master 0
// (CPU load/store port) and master 1 (DMA / debug loader).
//
// Parameters:
//   ARB_MODE  0 = master 0 priority with starvation guard, 1 = round-robin
//   MAX_WAIT  cycles master 1 may wait in mode 0 before it is forced to win (0 = no guard)
//   AW        address width
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   mX_req/we/addr/wdata/wstrb    master X access request and payload
//   mX_gnt                        combinational grant, access taken this cycle
//   mX_rvalid/rdata               registered read return, rdata is 0 when not valid
//   mem_en/we/addr/wdata/wstrb    memory command bus, all zero when idle
//   mem_rdata                     memory read data, valid the cycle after a read
module dmem_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 8,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [31:0]   m0_rdata,
    output logic [31:0]   m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata
);

    // Counter must be at least one bit wide even when the guard is disabled.
    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    logic           last_gnt;   // 0 = master 0 won last, 1 = master 1 won last
    logic [WCW-1:0] wait_cnt;
    owner_t         rd_owner;

    logic starved;
    logic conflict_m1;
    logic g0;
    logic g1;

    always_comb begin
        starved = (MAX_WAIT != 0) && (wait_cnt == WAIT_LIM);
        if (ARB_MODE == 0) begin
            conflict_m1 = starved;
        end else begin
            conflict_m1 = ~last_gnt;
        end
        // Grants are suppressed while reset is held so nothing reaches memory.
        g1 = rst & m1_req & (~m0_req | conflict_m1);
        g0 = rst & m0_req & ~g1;
    end

    assign m0_gnt = g0;
    assign m1_gnt = g1;

    always_comb begin
        mem_en    = g0 | g1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (g0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wstrb = m0_we ? m0_wstrb : 4'h0;
        end else if (g1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_we ? m1_wstrb : 4'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= 1'b1;
            wait_cnt <= '0;
            rd_owner <= OWN_NONE;
        end else begin
            if (g0) begin
                last_gnt <= 1'b0;
            end else if (g1) begin
                last_gnt <= 1'b1;
            end

            if (!m1_req || g1) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // Owner only lives for one cycle: it tags the mem_rdata of the next cycle.
            if (g0 && !m0_we) begin
                rd_owner <= OWN_M0;
            end else if (g1 && !m1_we) begin
                rd_owner <= OWN_M1;
            end else begin
                rd_owner <= OWN_NONE;
            end
        end
    end

    assign m0_rvalid = (rd_owner == OWN_M0);
    assign m1_rvalid = (rd_owner == OWN_M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - bench for dmem_arbiter, fixed-priority and round-robin instances side by side
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic        init_mem;
    logic        pre_en;
    logic [31:0] pre_addr, pre_data;

    int checks = 0;
    int errors = 0;

    // Per-instance outputs; instance 0 is mode 0 (MAX_WAIT 8), instance 1 is round-robin.
    logic        d0_m0_gnt, d0_m1_gnt, d0_m0_rvalid, d0_m1_rvalid, d0_mem_en, d0_mem_we;
    logic        d1_m0_gnt, d1_m1_gnt, d1_m0_rvalid, d1_m1_rvalid, d1_mem_en, d1_mem_we;
    logic [31:0] d0_m0_rdata, d0_m1_rdata, d0_mem_addr, d0_mem_wdata;
    logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_mem_addr, d1_mem_wdata;
    logic [3:0]  d0_mem_wstrb, d1_mem_wstrb;

    logic [1:0][31:0] mem_rdata_v;

    dmem_arbiter #(.ARB_MODE(0), .MAX_WAIT(8), .AW(32)) u_dut0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m0_gnt(d0_m0_gnt), .m1_gnt(d0_m1_gnt),
        .m0_rvalid(d0_m0_rvalid), .m1_rvalid(d0_m1_rvalid),
        .m0_rdata(d0_m0_rdata), .m1_rdata(d0_m1_rdata),
        .mem_en(d0_mem_en), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr),
        .mem_wdata(d0_mem_wdata), .mem_wstrb(d0_mem_wstrb), .mem_rdata(mem_rdata_v[0])
    );

    dmem_arbiter #(.ARB_MODE(1), .MAX_WAIT(8), .AW(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m0_gnt(d1_m0_gnt), .m1_gnt(d1_m1_gnt),
        .m0_rvalid(d1_m0_rvalid), .m1_rvalid(d1_m1_rvalid),
        .m0_rdata(d1_m0_rdata), .m1_rdata(d1_m1_rdata),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
        .mem_wdata(d1_mem_wdata), .mem_wstrb(d1_mem_wstrb), .mem_rdata(mem_rdata_v[1])
    );

    logic [1:0]       gnt0_v, gnt1_v, rv0_v, rv1_v, en_v, we_v;
    logic [1:0][31:0] rd0_v, rd1_v, addr_v, wdata_v;
    logic [1:0][3:0]  strb_v;

    always_comb begin
        gnt0_v     = {d1_m0_gnt, d0_m0_gnt};
        gnt1_v     = {d1_m1_gnt, d0_m1_gnt};
        rv0_v      = {d1_m0_rvalid, d0_m0_rvalid};
        rv1_v      = {d1_m1_rvalid, d0_m1_rvalid};
        en_v       = {d1_mem_en, d0_mem_en};
        we_v       = {d1_mem_we, d0_mem_we};
        rd0_v[0]   = d0_m0_rdata;
        rd0_v[1]   = d1_m0_rdata;
        rd1_v[0]   = d0_m1_rdata;
        rd1_v[1]   = d1_m1_rdata;
        addr_v[0]  = d0_mem_addr;
        addr_v[1]  = d1_mem_addr;
        wdata_v[0] = d0_mem_wdata;
        wdata_v[1] = d1_mem_wdata;
        strb_v[0]  = d0_mem_wstrb;
        strb_v[1]  = d1_mem_wstrb;
    end

    // One synchronous-read memory per instance, word indexed by addr[9:2].
    logic [31:0] mem [2][256];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_mem) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= 32'h0;
            end else begin
                if (pre_en) mem[k][pre_addr[9:2]] <= pre_data;
                if (en_v[k]) begin
                    if (we_v[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (strb_v[k][b]) mem[k][addr_v[k][9:2]][8*b +: 8] <= wdata_v[k][8*b +: 8];
                    end else begin
                        mem_rdata_v[k] <= mem[k][addr_v[k][9:2]];
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", nm, k, got, exp);
        end
    endtask

    // Reference model: who waited how long, who won most recently, which read
    // is outstanding and what data it must return (from a shadow memory).
    int          ref_wait [2];
    int          ref_last [2];
    int          ref_pend [2];
    logic [31:0] ref_pdata [2];
    logic [31:0] shadow [2][256];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int          g;
            logic        ewe;
            logic [31:0] ea, ewd;
            logic [3:0]  es;
            if (init_mem)
                for (int i = 0; i < 256; i++) shadow[k][i] = 32'h0;
            if (!rst) begin
                check("rst_m0_gnt", k, gnt0_v[k], 0);
                check("rst_m1_gnt", k, gnt1_v[k], 0);
                check("rst_mem_en", k, en_v[k], 0);
                check("rst_m0_rvalid", k, rv0_v[k], 0);
                check("rst_m1_rvalid", k, rv1_v[k], 0);
                ref_wait[k] = 0;
                ref_last[k] = 1;
                ref_pend[k] = 0;
            end else begin
                if (m0_req && m1_req) begin
                    if (k == 0) g = (ref_wait[k] >= 8) ? 2 : 1;
                    else        g = (ref_last[k] == 0) ? 2 : 1;
                end else if (m0_req) g = 1;
                else if (m1_req)     g = 2;
                else                 g = 0;
                ewe = 1'b0; ea = 32'h0; ewd = 32'h0; es = 4'h0;
                if (g == 1) begin ewe = m0_we; ea = m0_addr; ewd = m0_wdata; es = m0_we ? m0_wstrb : 4'h0; end
                if (g == 2) begin ewe = m1_we; ea = m1_addr; ewd = m1_wdata; es = m1_we ? m1_wstrb : 4'h0; end
                check("m0_gnt", k, gnt0_v[k], g == 1);
                check("m1_gnt", k, gnt1_v[k], g == 2);
                check("mem_en", k, en_v[k], g != 0);
                check("mem_we", k, we_v[k], ewe);
                check("mem_addr", k, addr_v[k], ea);
                check("mem_wdata", k, wdata_v[k], ewd);
                check("mem_wstrb", k, strb_v[k], es);
                check("m0_rvalid", k, rv0_v[k], ref_pend[k] == 1);
                check("m1_rvalid", k, rv1_v[k], ref_pend[k] == 2);
                check("m0_rdata", k, rd0_v[k], (ref_pend[k] == 1) ? ref_pdata[k] : 32'h0);
                check("m1_rdata", k, rd1_v[k], (ref_pend[k] == 2) ? ref_pdata[k] : 32'h0);
                if (g == 2 || !m1_req) ref_wait[k] = 0;
                else                   ref_wait[k] = ref_wait[k] + 1;
                if (g != 0) ref_last[k] = g - 1;
                ref_pend[k] = (g != 0 && !ewe) ? g : 0;
                ref_pdata[k] = shadow[k][ea[9:2]];
                if (g != 0 && ewe)
                    for (int b = 0; b < 4; b++)
                        if (es[b]) shadow[k][ea[9:2]][8*b +: 8] = ewd[8*b +: 8];
            end
            if (pre_en) shadow[k][pre_addr[9:2]] = pre_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
    endtask

    initial begin
        rst = 0; init_mem = 1; pre_en = 0; pre_addr = 0; pre_data = 0;
        idle();
        m0_req = 1; m1_req = 1;
        tick();
        init_mem = 0;
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("lit_reset_m0_gnt", k, gnt0_v[k], 0);
            check("lit_reset_m1_gnt", k, gnt1_v[k], 0);
            check("lit_reset_mem_en", k, en_v[k], 0);
        end
        tick();
        rst = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_release_m0_first", k, gnt0_v[k], 1);
        tick();
        idle();

        pre_en = 1; pre_addr = 32'h10; pre_data = 32'hDEADBEEF;
        tick();
        pre_en = 0;
        tick();

        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_single_m1_gnt", k, gnt1_v[k], 1);
        tick();
        idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("lit_single_m1_rvalid", k, rv1_v[k], 1);
            check("lit_single_m1_rdata", k, rd1_v[k], 32'hDEADBEEF);
            check("lit_single_m0_rvalid", k, rv0_v[k], 0);
        end
        tick();

        // Continuous contention: mode 0 gives m1 every 9th slot, round-robin alternates.
        m0_req = 1; m1_req = 1; m0_addr = 32'h40; m1_addr = 32'h10;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            check("lit_starve_m1_gnt", 0, gnt1_v[0], (i % 9) == 0);
            check("lit_rr_m1_gnt", 1, gnt1_v[1], (i % 2) == 0);
            tick();
        end
        idle();
        tick();

        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h12345678; m0_wstrb = 4'hF;
        tick();
        idle();
        m1_req = 1; m1_addr = 32'h20;
        tick();
        idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_b2b_m1_rdata", k, rd1_v[k], 32'h12345678);
        tick();

        m0_req = 1; m0_addr = 32'h10;
        tick();
        idle();
        rst = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_midrd_m0_rvalid", k, rv0_v[k], 0);
        tick();
        tick();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) check("lit_after_rst_m0_rvalid", k, rv0_v[k], 0);
            tick();
        end

        for (int n = 0; n < 3000; n++) begin
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 2) != 0);
            m0_we    = $urandom_range(0, 1);
            m1_we    = $urandom_range(0, 1);
            m0_addr  = $urandom_range(0, 1023);
            m1_addr  = $urandom_range(0, 1023);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            m0_wstrb = 4'($urandom_range(0, 15));
            m1_wstrb = 4'($urandom_range(0, 15));
            rst      = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
